regfile_read_arbiter: RTL
=========================

Name: regfile_read_arbiter

Overview:
- Shares the single 32-bit, 32-entry register-file read port (the 5-bit-select 32:1 read mux) among 2^IDW requesters, e.g. decode operand A/B, debug, and exception logic.
- A round-robin arbiter picks one requester per cycle and drives the mux select.
- The selected 32-bit word is registered and returned one cycle later, tagged with the requester ID.

Parameters:
- IDW, 2, requester ID width; NREQ = 2**IDW requesters (legal IDW: 1..3).
- DW, 32, data width of the read port.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req  input  NREQ  per-requester read request; bit i = requester i.
- req_addr  input  5*NREQ  packed register addresses; requester i at [5*i+4:5*i].
- port_hold  input  1  when 1, no grant is issued this cycle (port reserved, e.g. writeback/debug).
- port_data  input  DW  combinational output of the read mux for the current port_sel.
- port_sel  output  5  read-mux select.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as the winning req.
- rsp_valid  output  1  registered: rsp_data/rsp_id valid this cycle.
- rsp_id  output  IDW  registered: ID of the requester the response belongs to.
- rsp_data  output  DW  registered read data.

Behaviour:
- State: priority pointer ptr (IDW bits), response registers rsp_valid/rsp_id/rsp_data.
- Reset (reset=1 at edge): ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0. While reset is high, gnt=0 and port_sel=0 combinationally.
- Arbitration (combinational, cycle t):
  - eligible = req when port_hold=0, else 0.
  - Winner = first set bit of eligible scanning ptr, ptr+1, ... mod NREQ.
  - gnt = onehot(winner); port_sel = req_addr[winner].
  - If eligible=0: gnt=0, port_sel=0.
- Edge ending cycle t, with a grant:
  - rsp_valid<=1, rsp_id<=winner, rsp_data<=port_data.
  - ptr<=(winner+1) mod NREQ, wrapping naturally in IDW bits.
- Edge ending cycle t, no grant: rsp_valid<=0; rsp_id/rsp_data hold; ptr holds.
- Latency: exactly 1 cycle from grant to rsp_valid.
- Throughput: 1 read per cycle, back-to-back with no bubble.
- Requester contract:
  - Hold req=1 and a stable address until the gnt bit is seen.
  - May deassert the next cycle, or keep req high to issue another read.
  - A held request is re-arbitrated with the updated ptr.
- Fairness: with all NREQ requesters continuously active, each is granted exactly once per NREQ cycles. Maximum wait for an active requester is NREQ-1 granted cycles (port_hold cycles excluded).
- port_hold=1 blocks grants only; a response already in flight from the previous cycle still appears.
- A req dropped before grant is lost with no side effect; ptr is unaffected.
- Reset mid-stream: any pending response is discarded (rsp_valid=0 next cycle) and ptr returns to 0.
- Address 0 is not treated specially unless the optional feature is enabled.

Optional Feature:
- Macro: REGFILE_ARB_R0_ZERO_EN.
- Defined: a grant whose address is 0 still consumes the slot and advances ptr, but rsp_data<=0 regardless of port_data. Enforces architectural $r0=0 even if the array holds junk.
- Undefined: rsp_data always captures port_data.

Test Plan:
- Reset, then all req=0 for 5 cycles -> gnt=0, port_sel=0, rsp_valid=0 every cycle; rsp_data=0.
- Single requester 2, req_addr=7, port_data model returns 0xA5A5_0007 for sel 7 -> gnt=4'b0100 and port_sel=7 in cycle t; cycle t+1 rsp_valid=1, rsp_id=2, rsp_data=0xA5A5_0007.
- All 4 req held high for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_id follows one cycle later; rsp_valid continuously 1.
- req=4'b1010, port_hold=1 for 3 cycles, then 0 -> gnt=0 and rsp_valid=0 during hold; afterwards grant 1 then 3.
- Grant to requester 3 (ptr wraps to 0), then assert reset during the following cycle -> rsp_valid=0 after the reset edge; next grant with req=4'b1111 goes to requester 0.
- Requester 1 reads addr 0 with port_data=0xDEAD_BEEF -> rsp_data=0 with REGFILE_ARB_R0_ZERO_EN defined, 0xDEAD_BEEF without.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the single register-file read port; grant/select are combinational, data returns registered 1 cycle later.
// Optional REGFILE_ARB_R0_ZERO_EN forces read data of address 0 to zero; port_hold blocks grants, never an in-flight response.
module regfile_read_arbiter #(
    parameter int IDW = 2,
    parameter int DW  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2**IDW-1:0]     req,
    input  logic [5*(2**IDW)-1:0] req_addr,
    input  logic                  port_hold,
    input  logic [DW-1:0]         port_data,
    output logic [4:0]            port_sel,
    output logic [2**IDW-1:0]     gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data
);

    localparam int NREQ = 2**IDW;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_c;
    logic [4:0]      sel_c;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;
    logic            found;

    // Scan starting at ptr; the IDW-bit add wraps the scan modulo NREQ.
    always_comb begin
        elig  = (reset || port_hold) ? '0 : req;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        gnt_c = '0;
        sel_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + IDW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            gnt_c[win] = 1'b1;
            sel_c      = req_addr[5*int'(win) +: 5];
        end
    end

`ifdef REGFILE_ARB_R0_ZERO_EN
    assign rsp_data_d = (sel_c == 5'd0) ? '0 : port_data;
`else
    assign rsp_data_d = port_data;
`endif

    assign ptr_d = win + IDW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else if (found) begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win;
            rsp_data_q  <= rsp_data_d;
        end else begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign gnt       = gnt_c;
    assign port_sel  = sel_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
